// File: rtl/mux_8ne1_pkg.sv
// Shared constants and types for the 8:1 registered selector.
package mux_8ne1_pkg;

    localparam int N_INPUTS = 8;
    localparam int SEL_W    = 3;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux_8ne1_mux2ne1.sv
// 2:1 selector leaf used to build the 8:1 tree (sel=0 -> a, sel=1 -> b).
module mux2ne1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mux_8ne1.sv
// 8:1 selector built as a 4-2-1 tree of 2:1 leaves, with a registered copy
// of the selected data. The registered copy is taken while en is high; validQ marks it.
module mux_8ne1
    import mux_8ne1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] h0,
    input  logic [WIDTH-1:0] h1,
    input  logic [WIDTH-1:0] h2,
    input  logic [WIDTH-1:0] h3,
    input  logic [WIDTH-1:0] h4,
    input  logic [WIDTH-1:0] h5,
    input  logic [WIDTH-1:0] h6,
    input  logic [WIDTH-1:0] h7,
    input  sel_t             cline,
    input  logic             en,
    output logic [WIDTH-1:0] muxOut,
    output logic [WIDTH-1:0] muxOutQ,
    output logic             validQ
);

    logic [WIDTH-1:0] h_arr [N_INPUTS];
    logic [WIDTH-1:0] lvl1  [4];
    logic [WIDTH-1:0] lvl2  [2];
    logic [WIDTH-1:0] tree_out;

    assign h_arr[0] = h0;
    assign h_arr[1] = h1;
    assign h_arr[2] = h2;
    assign h_arr[3] = h3;
    assign h_arr[4] = h4;
    assign h_arr[5] = h5;
    assign h_arr[6] = h6;
    assign h_arr[7] = h7;

    for (genvar i = 0; i < 4; i++) begin : g_lvl1
        mux2ne1 #(.WIDTH(WIDTH)) u_mux (
            .a   (h_arr[2*i]),
            .b   (h_arr[2*i+1]),
            .sel (cline[0]),
            .y   (lvl1[i])
        );
    end

    for (genvar i = 0; i < 2; i++) begin : g_lvl2
        mux2ne1 #(.WIDTH(WIDTH)) u_mux (
            .a   (lvl1[2*i]),
            .b   (lvl1[2*i+1]),
            .sel (cline[1]),
            .y   (lvl2[i])
        );
    end

    mux2ne1 #(.WIDTH(WIDTH)) u_lvl3 (
        .a   (lvl2[0]),
        .b   (lvl2[1]),
        .sel (cline[2]),
        .y   (tree_out)
    );

    // Only fully known selects pass the tree output; an X/Z select falls to zero.
    always_comb begin
        muxOut = '0;
        case (cline)
            3'b000, 3'b001, 3'b010, 3'b011,
            3'b100, 3'b101, 3'b110, 3'b111: muxOut = tree_out;
            default:                         muxOut = '0;
        endcase
    end

    // Reset wins over en; validQ simply follows en one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            muxOutQ <= '0;
            validQ  <= 1'b0;
        end else begin
            validQ <= en;
            if (en) begin
                muxOutQ <= muxOut;
            end
        end
    end

endmodule

// File: tb/tb_mux_8ne1.sv
// Directed bench for mux_8ne1: a 1-bit and an 8-bit instance share clock and controls.
module tb_mux_8ne1;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] cline;
    logic [7:0] hv;
    logic       out1, q1, valid1;
    logic [7:0] h8 [8];
    logic [7:0] out8, q8;
    logic       valid8;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mux_8ne1 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .h0(hv[0]), .h1(hv[1]), .h2(hv[2]), .h3(hv[3]),
        .h4(hv[4]), .h5(hv[5]), .h6(hv[6]), .h7(hv[7]),
        .cline(cline), .en(en),
        .muxOut(out1), .muxOutQ(q1), .validQ(valid1)
    );

    mux_8ne1 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .h0(h8[0]), .h1(h8[1]), .h2(h8[2]), .h3(h8[3]),
        .h4(h8[4]), .h5(h8[5]), .h6(h8[6]), .h7(h8[7]),
        .cline(cline), .en(en),
        .muxOut(out8), .muxOutQ(q8), .validQ(valid8)
    );

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; cline = 3'd2; hv = 8'b0000_0100;
        tick(); tick();
        total++; if (q1 !== 1'b0) $display("FAIL reset_q1 got=%b exp=0", q1); else passed++;
        total++; if (valid1 !== 1'b0) $display("FAIL reset_valid1 got=%b exp=0", valid1); else passed++;
        total++; if (q8 !== 8'h00) $display("FAIL reset_q8 got=%h exp=00", q8); else passed++;
        total++; if (out1 !== 1'b1) $display("FAIL reset_comb_live got=%b exp=1", out1); else passed++;
        rst = 1'b0; en = 1'b0;
        tick();
        total++; if (valid1 !== 1'b0) $display("FAIL reset_release_valid got=%b exp=0", valid1); else passed++;
        total++; if (q1 !== 1'b0) $display("FAIL reset_release_q got=%b exp=0", q1); else passed++;
    endtask

    task automatic test_one_hot_walk();
        en = 1'b1;
        for (int n = 0; n < 8; n++) begin
            hv = 8'b1 << n;
            cline = 3'(n);
            #1;
            total++; if (out1 !== 1'b1) $display("FAIL walk_comb n=%0d got=%b exp=1", n, out1); else passed++;
            tick();
            total++; if (q1 !== 1'b1) $display("FAIL walk_q n=%0d got=%b exp=1", n, q1); else passed++;
            total++; if (valid1 !== 1'b1) $display("FAIL walk_valid n=%0d got=%b exp=1", n, valid1); else passed++;
        end
        en = 1'b0;
    endtask

    task automatic test_zero_select();
        hv = 8'h00; cline = 3'b110;
        #1;
        total++; if (out1 !== 1'b0) $display("FAIL zero_sel6 got=%b exp=0", out1); else passed++;
        hv = 8'b1000_0000; cline = 3'b111;
        #1;
        total++; if (out1 !== 1'b1) $display("FAIL zero_sel7 got=%b exp=1", out1); else passed++;
        tick();
    endtask

    task automatic test_isolation();
        en = 1'b1;
        for (int n = 0; n < 8; n++) begin
            hv = ~(8'b1 << n);
            cline = 3'(n);
            #1;
            total++; if (out1 !== 1'b0) $display("FAIL iso_comb n=%0d got=%b exp=0", n, out1); else passed++;
            tick();
            total++; if (q1 !== 1'b0) $display("FAIL iso_q n=%0d got=%b exp=0", n, q1); else passed++;
            hv = 8'bxxxx_xxxx;
            hv[n] = 1'b0;
            #1;
            total++; if (out1 !== 1'b0) $display("FAIL iso_x0 n=%0d got=%b exp=0", n, out1); else passed++;
            hv[n] = 1'b1;
            #1;
            total++; if (out1 !== 1'b1) $display("FAIL iso_x1 n=%0d got=%b exp=1", n, out1); else passed++;
        end
        en = 1'b0;
        hv = 8'h00;
        tick();
    endtask

    task automatic test_enable_hold();
        hv = 8'b0000_1000; cline = 3'b011; en = 1'b1;
        tick();
        total++; if (q1 !== 1'b1) $display("FAIL hold_capture got=%b exp=1", q1); else passed++;
        en = 1'b0; cline = 3'b000; hv = 8'b0000_1000;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (out1 !== 1'b0) $display("FAIL hold_comb k=%0d got=%b exp=0", k, out1); else passed++;
            tick();
            total++; if (q1 !== 1'b1) $display("FAIL hold_q k=%0d got=%b exp=1", k, q1); else passed++;
            total++; if (valid1 !== 1'b0) $display("FAIL hold_valid k=%0d got=%b exp=0", k, valid1); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        hv = 8'b0000_0001; cline = 3'd0; en = 1'b1;
        tick();
        total++; if (q1 !== 1'b1 || valid1 !== 1'b1)
            $display("FAIL mid_pre got=%b/%b exp=1/1", q1, valid1); else passed++;
        rst = 1'b1; hv = 8'b0010_0000; cline = 3'd5;
        #1;
        total++; if (out1 !== 1'b1) $display("FAIL mid_comb_in_reset got=%b exp=1", out1); else passed++;
        tick();
        total++; if (q1 !== 1'b0) $display("FAIL mid_q got=%b exp=0", q1); else passed++;
        total++; if (valid1 !== 1'b0) $display("FAIL mid_valid got=%b exp=0", valid1); else passed++;
        hv = 8'b0000_0000;
        #1;
        total++; if (out1 !== 1'b0) $display("FAIL mid_comb_track got=%b exp=0", out1); else passed++;
        rst = 1'b0; en = 1'b0; hv = 8'b0010_0000;
        tick();
        total++; if (q1 !== 1'b0 || valid1 !== 1'b0)
            $display("FAIL mid_idle got=%b/%b exp=0/0", q1, valid1); else passed++;
        en = 1'b1;
        tick();
        total++; if (q1 !== 1'b1 || valid1 !== 1'b1)
            $display("FAIL mid_resume got=%b/%b exp=1/1", q1, valid1); else passed++;
        en = 1'b0;
        tick();
    endtask

    task automatic test_width8();
        logic [7:0] exp_v;
        en = 1'b1;
        for (int n = 0; n < 8; n++) begin
            cline = 3'(n);
            exp_v = 8'h10 + 8'(n);
            #1;
            total++; if (out8 !== exp_v) $display("FAIL w8_comb n=%0d got=%h exp=%h", n, out8, exp_v); else passed++;
            tick();
            total++; if (q8 !== exp_v) $display("FAIL w8_q n=%0d got=%h exp=%h", n, q8, exp_v); else passed++;
        end
        en = 1'b0;
        cline = 3'd6;
        tick();
        total++; if (q8 !== 8'h17) $display("FAIL w8_hold got=%h exp=17", q8); else passed++;
        total++; if (valid8 !== 1'b0) $display("FAIL w8_valid got=%b exp=0", valid8); else passed++;
    endtask

    task automatic test_cline_x();
        en = 1'b0;
        hv = 8'b1111_1110;
        cline = 3'bxxx;
        #1;
        total++; if (out1 !== 1'b0) $display("FAIL clinex got=%b exp=0", out1); else passed++;
        cline = 3'd0;
        tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cline = 3'd0; hv = 8'h00;
        for (int i = 0; i < 8; i++) h8[i] = 8'h10 + 8'(i);
        test_reset();
        test_one_hot_walk();
        test_zero_select();
        test_isolation();
        test_enable_hold();
        test_reset_mid();
        test_width8();
        test_cline_x();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
